// File: rtl/jt89.sv
// SN76489-compatible PSG: three square-wave tones plus one LFSR noise channel, 4-bit attenuation each.
// Latency: a CPU write lands on the clk edge where wr_n is first seen low; channel outputs are registered on clk_en, and sound lags them by one clk_en.
// Backpressure: none. Every write is accepted immediately, and the outputs are free-running.
//
// Ports:
//   clk, rst (async, active-low), clk_en (PSG master tick), wr_n/din (CPU write port),
//   ch0..ch2/noise (9-bit signed per-channel contribution), sound (11-bit signed sum).
module jt89 (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              wr_n,
  input  logic [7:0]        din,
  output logic signed [8:0] ch0,
  output logic signed [8:0] ch1,
  output logic signed [8:0] ch2,
  output logic signed [8:0] noise,
  output logic signed [10:0] sound
);

  // ---------------------------------------------------------------------------
  // Register file and write decode
  // ---------------------------------------------------------------------------
  logic        last_wr_n;
  logic        wr_stb;
  logic [1:0]  latch_ch;
  logic        latch_vol;
  logic [9:0]  period [0:2];
  logic [3:0]  att    [0:3];
  logic [2:0]  noise_ctrl;

  logic [1:0]  tgt_ch;
  logic        tgt_vol;
  logic        att_we;
  logic        ctrl_we;
  logic        per_lo_we;
  logic        per_hi_we;

  // A write is the first clk edge that sees wr_n low. A long low pulse
  // therefore produces only one write, even if din moves during the pulse.
  assign wr_stb = ~wr_n & last_wr_n;

  always_comb begin
    tgt_ch    = latch_ch;
    tgt_vol   = latch_vol;
    if (din[7]) begin
      tgt_ch  = din[6:5];
      tgt_vol = din[4];
    end
    att_we    = wr_stb & tgt_vol;
    ctrl_we   = wr_stb & ~tgt_vol & (tgt_ch == 2'd3);
    per_lo_we = wr_stb &  din[7] & ~tgt_vol & (tgt_ch != 2'd3);
    per_hi_we = wr_stb & ~din[7] & ~tgt_vol & (tgt_ch != 2'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_wr_n  <= 1'b1;
      latch_ch   <= 2'd0;
      latch_vol  <= 1'b0;
      noise_ctrl <= 3'd0;
      for (int i = 0; i < 3; i++) period[i] <= 10'd0;
      for (int i = 0; i < 4; i++) att[i]    <= 4'hF;
    end else begin
      last_wr_n <= wr_n;
      if (wr_stb && din[7]) begin
        latch_ch  <= din[6:5];
        latch_vol <= din[4];
      end
      if (att_we)    att[tgt_ch]          <= din[3:0];
      if (ctrl_we)   noise_ctrl           <= din[2:0];
      if (per_lo_we) period[tgt_ch][3:0]  <= din[3:0];
      if (per_hi_we) period[tgt_ch][9:4]  <= din[5:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: one tick every 16 clk_en
  // ---------------------------------------------------------------------------
  logic [3:0] prescaler;
  logic       tick;

  assign tick = clk_en & (prescaler == 4'hF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= 4'd0;
    end else if (clk_en) begin
      prescaler <= prescaler + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tone generators
  // ---------------------------------------------------------------------------
  logic [9:0] tone_cnt [0:2];
  logic [2:0] tone_ff;
  logic [2:0] tone_bit;

  // The counter reloads when it reaches 1 (or sits at 0 after reset). That makes
  // the half-period exactly 'period' ticks. A period written mid-count is only
  // picked up at the next reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) tone_cnt[i] <= 10'd0;
      tone_ff <= 3'b000;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (tone_cnt[i] <= 10'd1) begin
          tone_cnt[i] <= period[i];
          tone_ff[i]  <= ~tone_ff[i];
        end else begin
          tone_cnt[i] <= tone_cnt[i] - 10'd1;
        end
      end
    end
  end

  // Periods 0 and 1 are above the audible range, so those channels sit at +amp.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      tone_bit[i] = (period[i] <= 10'd1) ? 1'b1 : tone_ff[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Noise generator
  // ---------------------------------------------------------------------------
  logic [6:0]  noise_cnt;
  logic [6:0]  noise_len;
  logic        noise_ff;
  logic        noise_clk;
  logic        noise_clk_q;
  logic        lfsr_fb;
  logic [15:0] lfsr;

  always_comb begin
    case (noise_ctrl[1:0])
      2'd0:    noise_len = 7'd16;
      2'd1:    noise_len = 7'd32;
      default: noise_len = 7'd64;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      noise_cnt <= 7'd0;
      noise_ff  <= 1'b0;
    end else if (tick) begin
      if (noise_cnt <= 7'd1) begin
        noise_cnt <= noise_len;
        noise_ff  <= ~noise_ff;
      end else begin
        noise_cnt <= noise_cnt - 7'd1;
      end
    end
  end

  // Rate 3 borrows tone 2's raw flip-flop, ignoring the period<=1 override.
  assign noise_clk = (noise_ctrl[1:0] == 2'd3) ? tone_ff[2] : noise_ff;
  assign lfsr_fb   = noise_ctrl[2] ? (lfsr[0] ^ lfsr[3]) : lfsr[0];

  // Any write to the noise control register restarts the sequence. The restart
  // takes priority over a shift landing on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      noise_clk_q <= 1'b0;
      lfsr        <= 16'h8000;
    end else begin
      noise_clk_q <= noise_clk;
      if (ctrl_we) begin
        lfsr <= 16'h8000;
      end else if (noise_clk && !noise_clk_q) begin
        lfsr <= {lfsr_fb, lfsr[15:1]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Attenuation and output stage
  // ---------------------------------------------------------------------------
  // Magnitudes follow 2 dB steps, and attenuation F is silence.
  function automatic logic [7:0] vol_mag(input logic [3:0] a);
    logic [7:0] m;
    case (a)
      4'd0:    m = 8'd255;
      4'd1:    m = 8'd203;
      4'd2:    m = 8'd161;
      4'd3:    m = 8'd128;
      4'd4:    m = 8'd102;
      4'd5:    m = 8'd81;
      4'd6:    m = 8'd64;
      4'd7:    m = 8'd51;
      4'd8:    m = 8'd40;
      4'd9:    m = 8'd32;
      4'd10:   m = 8'd26;
      4'd11:   m = 8'd20;
      4'd12:   m = 8'd16;
      4'd13:   m = 8'd13;
      4'd14:   m = 8'd10;
      default: m = 8'd0;
    endcase
    return m;
  endfunction

  function automatic logic signed [8:0] chan_val(input logic b, input logic [3:0] a);
    logic signed [8:0] mag;
    mag = $signed({1'b0, vol_mag(a)});
    return b ? mag : -mag;
  endfunction

  // sound is summed from the registered channel values, so it trails them by one
  // clk_en. Four 9-bit terms fit 11 bits without saturating (max |1020|).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch0   <= 9'sd0;
      ch1   <= 9'sd0;
      ch2   <= 9'sd0;
      noise <= 9'sd0;
      sound <= 11'sd0;
    end else if (clk_en) begin
      ch0   <= chan_val(tone_bit[0], att[0]);
      ch1   <= chan_val(tone_bit[1], att[1]);
      ch2   <= chan_val(tone_bit[2], att[2]);
      noise <= chan_val(lfsr[0], att[3]);
      sound <= {{2{ch0[8]}}, ch0} + {{2{ch1[8]}}, ch1} +
               {{2{ch2[8]}}, ch2} + {{2{noise[8]}}, noise};
    end
  end

endmodule

// File: tb/tb_jt89.sv
// Directed bench for jt89: reset, tone period/volume, constant-high periods, white and
// periodic noise, single-write-per-strobe, and asynchronous mid-run reset.
// Expected values are hand-derived: one tick = 16 clk with clk_en held high.
module tb_jt89;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clk_en = 1'b1;
  logic              wr_n = 1'b1;
  logic [7:0]        din = 8'h00;
  logic signed [8:0] ch0, ch1, ch2, noise;
  logic signed [10:0] sound;

  int checks = 0;
  int fails  = 0;

  jt89 dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .wr_n   (wr_n),
    .din    (din),
    .ch0    (ch0),
    .ch1    (ch1),
    .ch2    (ch2),
    .noise  (noise),
    .sound  (sound)
  );

  always #5 clk = ~clk;

  // Overall time limit, independent of the per-wait budgets.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    din  = b;
    wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic signed [8:0] sig(input int sel);
    case (sel)
      0:       return ch0;
      1:       return ch1;
      2:       return ch2;
      default: return noise;
    endcase
  endfunction

  // Count negedges until the selected output changes. n is the elapsed clk count.
  task automatic wait_change(input int sel, input int budget, output int n, output bit ok);
    logic signed [8:0] v0;
    v0 = sig(sel);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (sig(sel) !== v0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++; if (ch0   !== 9'sd0)  begin fails++; $display("FAIL reset_ch0: got %0d, required 0", ch0); end
    checks++; if (ch1   !== 9'sd0)  begin fails++; $display("FAIL reset_ch1: got %0d, required 0", ch1); end
    checks++; if (ch2   !== 9'sd0)  begin fails++; $display("FAIL reset_ch2: got %0d, required 0", ch2); end
    checks++; if (noise !== 9'sd0)  begin fails++; $display("FAIL reset_noise: got %0d, required 0", noise); end
    checks++; if (sound !== 11'sd0) begin fails++; $display("FAIL reset_sound: got %0d, required 0", sound); end
    rst = 1'b1;
    repeat (300) @(negedge clk);
    checks++; if (ch0   !== 9'sd0)  begin fails++; $display("FAIL idle_ch0: got %0d, required 0", ch0); end
    checks++; if (ch1   !== 9'sd0)  begin fails++; $display("FAIL idle_ch1: got %0d, required 0", ch1); end
    checks++; if (ch2   !== 9'sd0)  begin fails++; $display("FAIL idle_ch2: got %0d, required 0", ch2); end
    checks++; if (noise !== 9'sd0)  begin fails++; $display("FAIL idle_noise: got %0d, required 0", noise); end
    checks++; if (sound !== 11'sd0) begin fails++; $display("FAIL idle_sound: got %0d, required 0", sound); end
  endtask

  // ch0 period 0x0FE at full volume: +-255 square, half-period 254 ticks = 4064 clk.
  task automatic test_tone0();
    int n;
    bit ok;
    write_byte(8'h8E);
    write_byte(8'h0F);
    write_byte(8'h90);
    wait_change(0, 5000, n, ok);
    checks++; if (!ok) begin fails++; $display("FAIL tone0_first_edge: no ch0 edge after %0d clk, required an edge", n); end
    wait_change(0, 5000, n, ok);
    checks++; if (!ok || n != 4064) begin fails++; $display("FAIL tone0_half_period_a: got %0d clk, required 4064", n); end
    checks++; if (!(ch0 === 9'sd255 || ch0 === -9'sd255)) begin fails++; $display("FAIL tone0_level: got %0d, required +-255", ch0); end
    wait_change(0, 5000, n, ok);
    checks++; if (!ok || n != 4064) begin fails++; $display("FAIL tone0_half_period_b: got %0d clk, required 4064", n); end
    repeat (3) @(negedge clk);
    checks++; if (!(sound === 11'sd255 || sound === -11'sd255)) begin fails++; $display("FAIL tone0_sound: got %0d, required +-255", sound); end
    checks++; if (ch1 !== 9'sd0 || ch2 !== 9'sd0 || noise !== 9'sd0) begin
      fails++; $display("FAIL tone0_others: got %0d %0d %0d, required 0 0 0", ch1, ch2, noise);
    end
  endtask

  // ch1 period 1 is forced high; attenuation 3 gives magnitude 128.
  task automatic test_tone1_const();
    write_byte(8'hA1);
    write_byte(8'h00);
    write_byte(8'hB3);
    repeat (20) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++; if (ch1 !== 9'sd128) begin fails++; $display("FAIL tone1_const_%0d: got %0d, required 128", k, ch1); end
      checks++; if (!(sound === 11'sd383 || sound === -11'sd127)) begin
        fails++; $display("FAIL tone1_sound_%0d: got %0d, required 383 or -127", k, sound);
      end
      repeat (200) @(negedge clk);
    end
    checks++; if (ch2 !== 9'sd0 || noise !== 9'sd0) begin fails++; $display("FAIL tone1_others: got %0d %0d, required 0 0", ch2, noise); end
    write_byte(8'h9F);
    write_byte(8'hBF);
  endtask

  // One run of the white-noise sequence from a fresh 0x8000 seed. The first output
  // change is shift 15. Later shifts come every 512 clk and are sampled mid-interval.
  task automatic noise_white_run(input string tag);
    int n;
    bit ok;
    logic [15:0] m;
    repeat (4) @(negedge clk);
    checks++; if (noise !== -9'sd255) begin fails++; $display("FAIL %s_seed: got %0d, required -255", tag, noise); end
    m = 16'h8000;
    for (int s = 0; s < 15; s++) m = {m[0] ^ m[3], m[15:1]};
    wait_change(3, 9000, n, ok);
    checks++; if (!ok) begin fails++; $display("FAIL %s_first_edge: no noise edge after %0d clk, required an edge", tag, n); end
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 256 : 512) @(negedge clk);
      checks++;
      if (noise !== (m[0] ? 9'sd255 : -9'sd255)) begin
        fails++; $display("FAIL %s_bit%0d: got %0d, required %0d", tag, k, noise, m[0] ? 255 : -255);
      end
      m = {m[0] ^ m[3], m[15:1]};
    end
  endtask

  task automatic test_noise_white();
    write_byte(8'hE4);
    write_byte(8'hF0);
    noise_white_run("white");
    write_byte(8'hE4);
    noise_white_run("white_restart");
  endtask

  // ch2 period 0x020 toggles every 512 clk, so tone2 rises every 1024 clk. In periodic
  // mode the single 1 reaches bit 0 after 15 shifts and stays there for one shift.
  task automatic test_noise_periodic();
    int n;
    bit ok;
    write_byte(8'hC0);
    write_byte(8'h02);
    write_byte(8'hE3);
    repeat (4) @(negedge clk);
    checks++; if (noise !== -9'sd255) begin fails++; $display("FAIL periodic_seed: got %0d, required -255", noise); end
    wait_change(3, 20000, n, ok);
    checks++; if (!ok || noise !== 9'sd255) begin fails++; $display("FAIL periodic_pulse: got %0d after %0d clk, required 255", noise, n); end
    wait_change(3, 3000, n, ok);
    checks++; if (!ok || n != 1024) begin fails++; $display("FAIL periodic_width: got %0d clk, required 1024", n); end
    checks++; if (noise !== -9'sd255) begin fails++; $display("FAIL periodic_low: got %0d, required -255", noise); end
  endtask

  // Latch ch0 tone (low nibble 0) and write data 0x3F with a 10-clk low pulse. din
  // moves to 0x01 after the first edge, so only the first edge may take effect.
  // Period 0x3F0 = 1008 ticks = 16128 clk per half-period.
  task automatic test_data_long_wr();
    int n;
    bit ok;
    write_byte(8'h90);
    write_byte(8'h80);
    @(negedge clk);
    din  = 8'h3F;
    wr_n = 1'b0;
    @(negedge clk);
    din  = 8'h01;
    repeat (9) @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    wait_change(0, 5000, n, ok);
    checks++; if (!ok) begin fails++; $display("FAIL data_first_edge: no ch0 edge after %0d clk, required an edge", n); end
    wait_change(0, 17000, n, ok);
    checks++; if (!ok || n != 16128) begin fails++; $display("FAIL data_half_period: got %0d clk, required 16128", n); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (ch0   !== 9'sd0)  begin fails++; $display("FAIL midrst_ch0: got %0d, required 0", ch0); end
    checks++; if (noise !== 9'sd0)  begin fails++; $display("FAIL midrst_noise: got %0d, required 0", noise); end
    checks++; if (sound !== 11'sd0) begin fails++; $display("FAIL midrst_sound: got %0d, required 0", sound); end
    @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (ch0 !== 9'sd0 || ch1 !== 9'sd0 || ch2 !== 9'sd0 || noise !== 9'sd0 || sound !== 11'sd0) begin
      fails++; $display("FAIL midrst_after: got %0d %0d %0d %0d %0d, required all 0", ch0, ch1, ch2, noise, sound);
    end
  endtask

  initial begin
    test_reset();
    test_tone0();
    test_tone1_const();
    test_noise_white();
    test_noise_periodic();
    test_data_long_wr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
